// File: rtl/sm_muldiv.sv
// rtl/sm_muldiv.sv - iterative MIPS-style HI/LO multiply/divide unit
//
// Computes one result bit per clock (shift-add multiply, restoring divide)
// and keeps the result in the HI/LO registers read by MFHI/MFLO.
// Optional feature macro: SM_CONFIG_MULDIV_SIGNED_EN enables MULT (010) and
// DIV (011); without it those codes are no-ops and no sign logic exists.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        operation request, sampled at the rising edge
//   oper[2:0]    000 MULTU, 001 DIVU, 010 MULT, 011 DIV, 100 MTHI, 101 MTLO
//   srcA         multiplicand / dividend / MTHI-MTLO data
//   srcB         multiplier / divisor
//   busy         iterative operation in progress
//   done         one-cycle pulse when hi/lo carry a new result
//   hi, lo       HI/LO registers
module sm_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       oper,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_DIVU  = 3'b001;
`ifdef SM_CONFIG_MULDIV_SIGNED_EN
  localparam logic [2:0] OP_MULT  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
`endif
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic             state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;     // upper accumulator / partial remainder
  logic [WIDTH-1:0] mq_q, mq_d;       // multiplier / dividend-then-quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand / divisor
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             iter_req;
  logic [WIDTH-1:0] a_mag, b_mag;

`ifdef SM_CONFIG_MULDIV_SIGNED_EN
  logic neg_res_q, neg_res_d;   // negate product / quotient at the end
  logic neg_rem_q, neg_rem_d;   // negate remainder at the end
  logic neg_res_new, neg_rem_new;
  logic a_neg, b_neg;

  always_comb begin
    iter_req = start & ((oper == OP_MULTU) | (oper == OP_DIVU) |
                        (oper == OP_MULT)  | (oper == OP_DIV));
    a_neg = oper[1] & srcA[WIDTH-1];
    b_neg = oper[1] & srcB[WIDTH-1];
    a_mag = a_neg ? (~srcA + 1'b1) : srcA;
    b_mag = b_neg ? (~srcB + 1'b1) : srcB;
    // On divide-by-zero the natural quotient is all ones; keep it unnegated.
    // The remainder then equals |A| and regains A's sign, giving hi = srcA.
    neg_res_new = (a_neg ^ b_neg) & ~(oper[0] & (srcB == '0));
    neg_rem_new = a_neg;
  end
`else
  always_comb begin
    iter_req = start & ((oper == OP_MULTU) | (oper == OP_DIVU));
    a_mag    = srcA;
    b_mag    = srcB;
  end
`endif

  // One iteration step for each algorithm.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH+1:0] div_diff;
  logic             div_ok;
  logic [WIDTH:0]   step_acc;
  logic [WIDTH-1:0] step_mq;
  logic [WIDTH-1:0] res_hi, res_lo;

  always_comb begin
    mul_sum  = {1'b0, acc_q[WIDTH-1:0]} + (mq_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
    div_diff = {1'b0, div_sh} - {2'b00, opnd_q};
    div_ok   = ~div_diff[WIDTH+1];
    if (is_div_q) begin
      step_acc = div_ok ? div_diff[WIDTH:0] : div_sh;
      step_mq  = {mq_q[WIDTH-2:0], div_ok};
    end else begin
      step_acc = {1'b0, mul_sum[WIDTH:1]};
      step_mq  = {mul_sum[0], mq_q[WIDTH-1:1]};
    end
  end

  // Final result from the last step, with sign correction when enabled.
  always_comb begin
    res_hi = step_acc[WIDTH-1:0];
    res_lo = step_mq;
`ifdef SM_CONFIG_MULDIV_SIGNED_EN
    if (is_div_q) begin
      if (neg_res_q) res_lo = ~step_mq + 1'b1;
      if (neg_rem_q) res_hi = ~step_acc[WIDTH-1:0] + 1'b1;
    end else if (neg_res_q) begin
      {res_hi, res_lo} = ~{step_acc[WIDTH-1:0], step_mq} + 1'b1;
    end
`endif
  end

  always_comb begin
    logic accept;
    accept   = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef SM_CONFIG_MULDIV_SIGNED_EN
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
`endif
    if (state_q == ST_IDLE) begin
      if (iter_req) begin
        accept = 1'b1;
      end else if (start && oper == OP_MTHI) begin
        hi_d = srcA;
      end else if (start && oper == OP_MTLO) begin
        lo_d = srcA;
      end
    end else begin
      acc_d = step_acc;
      mq_d  = step_mq;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        hi_d    = res_hi;
        lo_d    = res_lo;
        done_d  = 1'b1;
        state_d = ST_IDLE;
        // The finishing edge may also accept the next iterative request.
        accept  = iter_req;
      end
    end
    if (accept) begin
      state_d  = ST_RUN;
      cnt_d    = CW'(WIDTH);
      acc_d    = '0;
      is_div_d = oper[0];
      mq_d     = oper[0] ? a_mag : b_mag;
      opnd_d   = oper[0] ? b_mag : a_mag;
`ifdef SM_CONFIG_MULDIV_SIGNED_EN
      neg_res_d = neg_res_new;
      neg_rem_d = neg_rem_new;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
`ifdef SM_CONFIG_MULDIV_SIGNED_EN
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
`ifdef SM_CONFIG_MULDIV_SIGNED_EN
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_sm_muldiv.sv
// tb/tb_sm_muldiv.sv - self-checking bench for sm_muldiv
module tb_sm_muldiv;

  localparam int W = 32;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   oper  = 3'b111;
  logic [W-1:0] srcA  = '0;
  logic [W-1:0] srcB  = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  sm_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .oper(oper),
    .srcA(srcA), .srcB(srcB), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: whole results from plain arithmetic, plus a
  // countdown of the documented latency.
  function automatic logic is_iter(input logic [2:0] op);
`ifdef SM_CONFIG_MULDIV_SIGNED_EN
    return op <= 3'b011;
`else
    return op <= 3'b001;
`endif
  endfunction

  function automatic logic [2*W-1:0] model_result(input logic [2:0] op,
                                                  input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
    logic [2*W-1:0]        p;
    logic signed [2*W-1:0] sp;
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'b000: p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      3'b001: p = (b == 0) ? {a, {W{1'b1}}} : {a % b, a / b};
      3'b010: begin
        sp = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        p  = sp;
      end
      default: begin
        if (sb == 0)                          p = {a, {W{1'b1}}};
        else if (sa == 32'sh80000000 && sb == -1) p = {{W{1'b0}}, a};
        else                                  p = {W'(sa % sb), W'(sa / sb)};
      end
    endcase
    return p;
  endfunction

  logic [W-1:0]   m_hi = '0, m_lo = '0;
  logic [2*W-1:0] p_res = '0;
  int             m_cnt = 0;
  logic           m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_cnt  <= 0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_hi   <= p_res[2*W-1:W];
          m_lo   <= p_res[W-1:0];
          m_done <= 1'b1;
        end
      end
      if (start && (m_cnt <= 1) && is_iter(oper)) begin
        p_res <= model_result(oper, srcA, srcB);
        m_cnt <= W;
      end else if (start && m_cnt == 0 && oper == 3'b100) begin
        m_hi <= srcA;
      end else if (start && m_cnt == 0 && oper == 3'b101) begin
        m_lo <= srcA;
      end
    end
  end

  // Cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_busy", {31'b0, busy}, {31'b0, m_cnt != 0});
      chk("cmp_done", {31'b0, done}, {31'b0, m_done});
      chk("cmp_hi", hi, m_hi);
      chk("cmp_lo", lo, m_lo);
    end
  end

  task automatic pulse(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; oper = op; srcA = a; srcB = b;
    @(posedge clk); #1;
    start = 1'b0; oper = 3'b111;
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    pulse(op, a, b);
  endtask

  // Counts edges until done and the busy samples seen before it.
  task automatic wait_done(output int cyc, output int nbusy);
    logic seen;
    seen  = 1'b0;
    cyc   = 0;
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) nbusy++;
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", {31'b0, seen}, 32'd1);
  endtask

  int cyc, nb, ndone;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    rst_n = 1'b1;

    issue(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(cyc, nb);
    chk("multu_latency", cyc, 32);
    chk("multu_busy_cycles", nb, 32);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'b0, done}, 32'd0);

    issue(3'b001, 32'd100, 32'd7);
    wait_done(cyc, nb);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    issue(3'b001, 32'd5, 32'd0);
    wait_done(cyc, nb);
    chk("divu0_lo", lo, 32'hFFFFFFFF);
    chk("divu0_hi", hi, 32'd5);

`ifdef SM_CONFIG_MULDIV_SIGNED_EN
    issue(3'b011, 32'hFFFFFFF9, 32'd2);
    wait_done(cyc, nb);
    chk("div_neg_lo", lo, 32'hFFFFFFFD);
    chk("div_neg_hi", hi, 32'hFFFFFFFF);
    issue(3'b011, 32'h80000000, 32'hFFFFFFFF);
    wait_done(cyc, nb);
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 32'h0);
    issue(3'b010, 32'hFFFFFFFD, 32'd5);
    wait_done(cyc, nb);
    chk("mult_neg_hi", hi, 32'hFFFFFFFF);
    chk("mult_neg_lo", lo, 32'hFFFFFFF1);
    issue(3'b011, 32'hFFFFFFF9, 32'd0);
    wait_done(cyc, nb);
    chk("div0_signed_lo", lo, 32'hFFFFFFFF);
    chk("div0_signed_hi", hi, 32'hFFFFFFF9);
`else
    issue(3'b010, 32'd3, 32'd4);
    issue(3'b011, 32'd100, 32'd7);
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy || done) ndone++;
      @(posedge clk); #1;
    end
    chk("signed_noop_activity", ndone, 0);
    chk("signed_noop_hi", hi, 32'd5);
    chk("signed_noop_lo", lo, 32'hFFFFFFFF);
`endif

    issue(3'b000, 32'd3, 32'd4);
    pulse(3'b100, 32'h55, 32'h0);
    pulse(3'b001, 32'd9, 32'd2);
    wait_done(cyc, nb);
    chk("ignored_latency", cyc, 30);
    chk("ignored_hi", hi, 32'h0);
    chk("ignored_lo", lo, 32'd12);
    issue(3'b101, 32'hAA, 32'h0);
    chk("mtlo_lo", lo, 32'hAA);
    chk("mtlo_done", {31'b0, done}, 32'd0);
    chk("mtlo_busy", {31'b0, busy}, 32'd0);
    issue(3'b100, 32'h1234, 32'h0);
    chk("mthi_hi", hi, 32'h1234);

    issue(3'b000, 32'd7, 32'd9);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    issue(3'b000, 32'hFFFFFFFF, 32'd2);
    repeat (31) @(posedge clk);
    #1;
    start = 1'b1; oper = 3'b000; srcA = 32'd5; srcB = 32'd6;
    @(posedge clk); #1;
    start = 1'b0; oper = 3'b111;
    chk("b2b_done", {31'b0, done}, 32'd1);
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    chk("b2b_hi1", hi, 32'h1);
    chk("b2b_lo1", lo, 32'hFFFFFFFE);
    wait_done(cyc, nb);
    chk("b2b_latency", cyc, 32);
    chk("b2b_hi2", hi, 32'h0);
    chk("b2b_lo2", lo, 32'd30);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
